// File: rtl/wave_cap_pkg.sv
// Shared definitions for the waveform capture path: default widths and the
// capture FSM state encoding.
package wave_cap_pkg;

    localparam int DEF_ADDR_W       = 10;
    localparam int DEF_DATA_W       = 8;
    localparam int DEF_DECIM_W      = 16;
    localparam int DEF_TRIG_TIMEOUT = 4096;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TRIG = 2'd1,
        FILL      = 2'd2,
        DONE      = 2'd3
    } cap_state_e;

endpackage

// File: rtl/wave_cap_ram.sv
// Two-bank sample store: simple dual-port RAM, bank selected by the address MSB,
// registered read port so it maps onto block RAM.
module wave_cap_ram
    import wave_cap_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W:0]   waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W:0]   raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [0:(2**(ADDR_W+1))-1];
    logic [DATA_W-1:0] rdata_r;

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        rdata_r <= mem_r[raddr];
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/wave_capture_buffer.sv
// Captures decimated, level-triggered DDS samples into the write bank of a
// ping-pong line buffer while the LCD reads the frozen display bank.
module wave_capture_buffer
    import wave_cap_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int DECIM_W      = DEF_DECIM_W,
    parameter int TRIG_TIMEOUT = DEF_TRIG_TIMEOUT
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  sample_i,
    input  logic               sample_valid_i,
    input  logic [DECIM_W-1:0] decim_i,
    input  logic [DATA_W-1:0]  trig_level_i,
    input  logic               trig_en_i,
    input  logic               frame_start_i,
    input  logic [ADDR_W:0]    rd_addr_i,
    output logic [DATA_W-1:0]  rd_data_o,
    output logic               capture_done_o,
    output logic               triggered_o,
    output logic               bank_o
);

    localparam int TMO_W = $clog2(TRIG_TIMEOUT);
    localparam logic [TMO_W-1:0]   TMO_ZERO   = {TMO_W{1'b0}};
    localparam logic [TMO_W-1:0]   TMO_ONE    = TMO_W'(1);
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TRIG_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0]  ADDR_ZERO  = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0]  ADDR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0]  WADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [DECIM_W-1:0] DECIM_ZERO = {DECIM_W{1'b0}};
    localparam logic [DECIM_W-1:0] DECIM_ONE  = DECIM_W'(1);
    localparam logic [DATA_W-1:0]  DATA_ZERO  = {DATA_W{1'b0}};

    cap_state_e         state_r;
    logic [DECIM_W-1:0] decim_cnt_r;
    logic [DATA_W-1:0]  prev_r;
    logic               prev_valid_r;
    logic [ADDR_W-1:0]  waddr_r;
    logic [TMO_W-1:0]   tmo_cnt_r;
    logic               triggered_r;
    logic               capture_done_r;
    logic               bank_r;
    logic               disp_valid_r;
    logic               rd_ok_r;

    logic               keep_s;
    logic               trig_hit_s;
    logic               go_fill_s;
    logic               wr_en_s;
    logic [DATA_W-1:0]  ram_rdata_s;

    // Kept-sample, trigger and write-enable decode
    always_comb begin
        keep_s     = sample_valid_i && (decim_cnt_r == DECIM_ZERO);
        trig_hit_s = prev_valid_r && (prev_r < trig_level_i) && (sample_i >= trig_level_i);
        go_fill_s  = !trig_en_i || trig_hit_s || (tmo_cnt_r == TMO_LAST);
        wr_en_s    = 1'b0;
        if (keep_s && (state_r == FILL)) begin
            wr_en_s = 1'b1;
        end else if (keep_s && (state_r == WAIT_TRIG) && go_fill_s) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Decimation counter and previous kept sample; both run regardless of capture state
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            decim_cnt_r  <= DECIM_ZERO;
            prev_r       <= DATA_ZERO;
            prev_valid_r <= 1'b0;
        end else if (sample_valid_i) begin
            if (keep_s) begin
                decim_cnt_r  <= decim_i;
                prev_r       <= sample_i;
                prev_valid_r <= 1'b1;
            end else begin
                decim_cnt_r  <= decim_cnt_r - DECIM_ONE;
            end
        end
    end

    // Capture FSM with bank swap; the transition sample lands at address 0
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            waddr_r        <= ADDR_ZERO;
            tmo_cnt_r      <= TMO_ZERO;
            triggered_r    <= 1'b0;
            capture_done_r <= 1'b0;
            bank_r         <= 1'b0;
            disp_valid_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r     <= WAIT_TRIG;
                    waddr_r     <= ADDR_ZERO;
                    tmo_cnt_r   <= TMO_ZERO;
                    triggered_r <= 1'b0;
                end
                WAIT_TRIG: begin
                    if (keep_s) begin
                        if (go_fill_s) begin
                            state_r     <= FILL;
                            waddr_r     <= ADDR_ONE;
                            triggered_r <= trig_en_i && trig_hit_s;
                        end else begin
                            tmo_cnt_r   <= tmo_cnt_r + TMO_ONE;
                        end
                    end
                end
                FILL: begin
                    if (keep_s) begin
                        waddr_r <= waddr_r + ADDR_ONE;
                        if (waddr_r == WADDR_LAST) begin
                            state_r        <= DONE;
                            capture_done_r <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (frame_start_i) begin
                        bank_r         <= ~bank_r;
                        disp_valid_r   <= 1'b1;
                        capture_done_r <= 1'b0;
                        state_r        <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Read qualifier aligned with the RAM's registered output
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ok_r <= 1'b0;
        end else begin
            rd_ok_r <= disp_valid_r && !rd_addr_i[ADDR_W];
        end
    end

    // Writer always targets the bank the display is not reading
    wave_cap_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (sys_clk),
        .we    (wr_en_s),
        .waddr ({~bank_r, waddr_r}),
        .wdata (sample_i),
        .raddr ({bank_r, rd_addr_i[ADDR_W-1:0]}),
        .rdata (ram_rdata_s)
    );

    assign rd_data_o      = rd_ok_r ? ram_rdata_s : DATA_ZERO;
    assign capture_done_o = capture_done_r;
    assign triggered_o    = triggered_r;
    assign bank_o         = bank_r;

endmodule

// File: tb/tb_wave_capture_buffer.sv
// Self-checking bench for wave_capture_buffer: read-back scoreboard, table of
// read vectors and hand-written capture/swap/reset sequences.
module tb_wave_capture_buffer;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic [7:0]  sample_i;
    logic        sample_valid_i;
    logic [15:0] decim_i;
    logic [7:0]  trig_level_i;
    logic        trig_en_i;
    logic        frame_start_i;
    logic [10:0] rd_addr_i;
    logic [7:0]  rd_data_o;
    logic        capture_done_o;
    logic        triggered_o;
    logic        bank_o;

    typedef struct {
        logic [10:0] addr;
        logic [7:0]  exp;
    } rd_vec_t;

    rd_vec_t    s1_tbl [0:9];
    logic [7:0] exp_q [$];
    int         checks = 0;
    int         errors = 0;
    int         n_drv  = 0;
    int         cons;

    always #5 sys_clk = ~sys_clk;

    wave_capture_buffer dut (
        .sys_clk        (sys_clk),
        .rst_n          (rst_n),
        .sample_i       (sample_i),
        .sample_valid_i (sample_valid_i),
        .decim_i        (decim_i),
        .trig_level_i   (trig_level_i),
        .trig_en_i      (trig_en_i),
        .frame_start_i  (frame_start_i),
        .rd_addr_i      (rd_addr_i),
        .rd_data_o      (rd_data_o),
        .capture_done_o (capture_done_o),
        .triggered_o    (triggered_o),
        .bank_o         (bank_o)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One cycle: land on the falling edge and retire the read issued a cycle ago.
    task automatic tick();
        logic [7:0] e;
        @(negedge sys_clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rd_data", int'(rd_data_o), int'(e));
        end
    endtask

    task automatic issue_read(input logic [10:0] a, input logic [7:0] e);
        rd_addr_i = a;
        exp_q.push_back(e);
    endtask

    task automatic release_reset();
        sample_valid_i = 1'b0;
        frame_start_i  = 1'b0;
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b1;
        n_drv = 0;
        exp_q.delete();
    endtask

    // Feed samples until capture_done_o; cons = samples consumed, -1 on timeout.
    task automatic run_capture(input bit use_ramp, input int bound, input int fs_idx,
                               output int consumed);
        consumed = -1;
        for (int k = 0; k < bound; k++) begin
            tick();
            if (capture_done_o) begin
                consumed = n_drv;
                break;
            end
            if (k % 100 == 50) check("bank_frozen", int'(bank_o), 0);
            sample_i       = use_ramp ? 8'(n_drv) : 8'd10;
            sample_valid_i = 1'b1;
            frame_start_i  = (k % 100 == 50) || (n_drv == fs_idx);
            if (k % 100 == 50) issue_read(11'd3, 8'd0);
            n_drv++;
        end
        sample_valid_i = 1'b0;
        frame_start_i  = 1'b0;
    endtask

    task automatic do_swap();
        repeat (3) tick();
        check("bank_before_swap", int'(bank_o), 0);
        check("done_held", int'(capture_done_o), 1);
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
        tick();
        check("bank_after_swap", int'(bank_o), 1);
        check("done_cleared", int'(capture_done_o), 0);
    endtask

    initial begin
        s1_tbl[0] = '{11'd0,    8'd128};
        s1_tbl[1] = '{11'd1,    8'd129};
        s1_tbl[2] = '{11'd5,    8'd133};
        s1_tbl[3] = '{11'd127,  8'd255};
        s1_tbl[4] = '{11'd128,  8'd0};
        s1_tbl[5] = '{11'd1023, 8'd127};
        s1_tbl[6] = '{11'd1024, 8'd0};
        s1_tbl[7] = '{11'd1500, 8'd0};
        s1_tbl[8] = '{11'd2047, 8'd0};
        s1_tbl[9] = '{11'd5,    8'd133};

        rst_n          = 1'b0;
        sample_i       = 8'd0;
        sample_valid_i = 1'b0;
        decim_i        = 16'd0;
        trig_level_i   = 8'd128;
        trig_en_i      = 1'b1;
        frame_start_i  = 1'b0;
        rd_addr_i      = 11'd0;
        release_reset();
        tick();
        check("reset_rd_data", int'(rd_data_o), 0);
        check("reset_done", int'(capture_done_o), 0);
        check("reset_triggered", int'(triggered_o), 0);
        check("reset_bank", int'(bank_o), 0);

        // Ramp, no decimation, frame_start pulses during FILL and on the last write
        run_capture(1'b1, 3000, 1151, cons);
        check("s1_consumed", cons, 1152);
        check("s1_triggered", int'(triggered_o), 1);
        do_swap();
        for (int i = 0; i < 10; i++) begin
            tick();
            issue_read(s1_tbl[i].addr, s1_tbl[i].exp);
        end
        tick();

        // Second capture, interrupted by an asynchronous reset mid-FILL
        for (int k = 0; k < 700; k++) begin
            tick();
            sample_i       = 8'(n_drv);
            sample_valid_i = 1'b1;
            n_drv++;
            if (k == 699) issue_read(11'd0, 8'd128);
        end
        tick();
        check("s6_pre_done", int'(capture_done_o), 0);
        check("s6_pre_triggered", int'(triggered_o), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rd_data", int'(rd_data_o), 0);
        check("async_done", int'(capture_done_o), 0);
        check("async_triggered", int'(triggered_o), 0);
        check("async_bank", int'(bank_o), 0);
        decim_i = 16'd3;
        release_reset();

        // Decimate by 4 after the reset
        run_capture(1'b1, 6000, -1, cons);
        check("s2_consumed", cons, 4221);
        check("s2_triggered", int'(triggered_o), 1);
        do_swap();
        for (int a = 0; a < 2048; a += 31) begin
            tick();
            issue_read(11'(a), (a < 1024) ? 8'((128 + 4 * a) & 255) : 8'd0);
        end
        tick();

        // Constant below the level: timeout-forced capture
        rst_n = 1'b0;
        decim_i = 16'd0;
        release_reset();
        run_capture(1'b0, 6000, -1, cons);
        check("s3_consumed", cons, 5119);
        check("s3_triggered", int'(triggered_o), 0);
        do_swap();
        for (int a = 0; a < 1100; a += 100) begin
            tick();
            issue_read(11'(a), (a < 1024) ? 8'd10 : 8'd0);
        end
        tick();
        issue_read(11'd1023, 8'd10);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
